// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcodes, FSM states and instruction field positions
package gpu_pkg;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_HALT} opcode_t;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, DONE} state_t;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam int OP_W    = 4;
  localparam int IMM_W   = 8;
endpackage

// File: rtl/simt_lane.sv
// simt_lane: one lane's register file, operand/result latches and ALU
module simt_lane
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int LANE_ID    = 0,
  localparam int RW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  ex_en,
  input  logic                  wb_en,
  input  logic [OP_W-1:0]       op,
  input  logic [RW-1:0]         rd,
  input  logic [RW-1:0]         rs1,
  input  logic [RW-1:0]         rs2,
  input  logic [IMM_W-1:0]      imm,
  input  logic [RW-1:0]         dbg_reg,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);
  logic [DATA_WIDTH-1:0] regs [2**RW];
  logic [DATA_WIDTH-1:0] a, b, res, alu;
  function automatic logic [DATA_WIDTH-1:0] rf(input logic [RW-1:0] r);
    return r == '0 ? '0 : r == RW'(NUM_REGS - 1) ? DATA_WIDTH'(LANE_ID) : regs[r];
  endfunction
  always_comb begin
    alu = op == OP_ADD ? a + b :
          op == OP_SUB ? a - b :
          op == OP_MUL ? a * b :
          op == OP_AND ? a & b :
          op == OP_OR  ? a | b :
          op == OP_XOR ? a ^ b : DATA_WIDTH'(imm);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2**RW; i++) regs[i] <= '0;
      a   <= '0;
      b   <= '0;
      res <= '0;
    end else begin
      if (rd_en) begin
        a <= rf(rs1);
        b <= rf(rs2);
      end
      if (ex_en) res <= alu;
      if (wb_en && rd != '0 && rd != RW'(NUM_REGS - 1)) regs[rd] <= res;
    end
  end
  assign dbg_rdata = rf(dbg_reg);
endmodule

// File: rtl/simt_core.sv
// simt_core: lockstep multi-lane core with FSM, PC, instruction memory and debug mux
module simt_core
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 16,
  parameter int IMEM_DEPTH  = 64,
  localparam int TW         = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1,
  localparam int RW         = $clog2(NUM_REGS),
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  imem_we,
  input  logic [AW-1:0]         imem_addr,
  input  logic [31:0]           imem_wdata,
  input  logic [TW-1:0]         dbg_thread,
  input  logic [RW-1:0]         dbg_reg,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [AW-1:0]         pc_o
);
  state_t state, nxt;
  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] ir;
  logic [OP_W-1:0] op;
  logic launch, unused_hi;
  logic [DATA_WIDTH-1:0] lane_rdata [NUM_THREADS];
  assign unused_hi = ^imem_wdata[31:16];
  assign op = ir[OP_LSB +: OP_W];
  assign launch = (state == IDLE || state == DONE) && start;
  always_comb begin
    nxt = state == IDLE || state == DONE ? (start ? FETCH : state) :
          state == FETCH                 ? DECODE :
          state == DECODE                ? (op == OP_HALT ? DONE : EXECUTE) :
          state == EXECUTE               ? WRITEBACK :
          state == WRITEBACK             ? (pc_o == AW'(IMEM_DEPTH - 1) ? DONE : FETCH) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc_o  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ir    <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt == FETCH || nxt == DECODE || nxt == EXECUTE || nxt == WRITEBACK;
      done  <= nxt == DONE;
      if (state == FETCH) ir <= imem[pc_o];
      pc_o  <= launch ? '0 : (state == WRITEBACK && nxt == FETCH) ? pc_o + 1'b1 : pc_o;
    end
  end
  always_ff @(posedge clk) begin
    if (imem_we && !busy) imem[imem_addr] <= imem_wdata[15:0];
  end
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    simt_lane #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .LANE_ID(t)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (state == DECODE),
      .ex_en    (state == EXECUTE),
      .wb_en    (state == WRITEBACK && op <= OP_LDI),
      .op       (op),
      .rd       (ir[RD_LSB +: RW]),
      .rs1      (ir[RS1_LSB +: RW]),
      .rs2      (ir[RS2_LSB +: RW]),
      .imm      (ir[IMM_LSB +: IMM_W]),
      .dbg_reg  (dbg_reg),
      .dbg_rdata(lane_rdata[t])
    );
  end
  assign dbg_rdata = int'(dbg_thread) < NUM_THREADS ? lane_rdata[dbg_thread] : '0;
endmodule

// File: tb/tb_simt_core.sv
// tb_simt_core: randomized and directed checks of simt_core against a program-level model
module tb_simt_core;
  localparam int NT = 4, DW = 16, NR = 16, ID = 64;
  logic clk = 0, reset = 0, start = 0, imem_we = 0;
  logic [5:0] imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [1:0] dbg_thread = '0;
  logic [3:0] dbg_reg = '0;
  logic [DW-1:0] dbg_rdata;
  logic busy, done;
  logic [5:0] pc_o;
  logic start8 = 0, we8 = 0;
  logic [2:0] addr8 = '0;
  logic [31:0] wdata8 = '0;
  logic [DW-1:0] dbg_rdata8;
  logic busy8, done8;
  logic [2:0] pc8;
  int vectors = 0, miscompares = 0;
  logic [31:0] mimem [ID];
  logic [DW-1:0] mregs [NT][NR];

  simt_core dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dbg_thread(dbg_thread), .dbg_reg(dbg_reg), .dbg_rdata(dbg_rdata), .pc_o(pc_o)
  );
  simt_core #(.IMEM_DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8),
    .dbg_thread(dbg_thread), .dbg_reg(dbg_reg), .dbg_rdata(dbg_rdata8), .pc_o(pc8)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mrd(input int l, input int r);
    return r == 0 ? '0 : r == NR - 1 ? DW'(l) : mregs[l][r];
  endfunction

  // Interprets the program in the model memory; returns expected done edge and final pc
  task automatic model_run(output int edges, output int pcf);
    int pc = 0;
    forever begin
      int op = int'(mimem[pc][15:12]);
      int rd = int'(mimem[pc][11:8]);
      int s1 = int'(mimem[pc][7:4]);
      int s2 = int'(mimem[pc][3:0]);
      if (op == 7) begin edges = 4 * pc + 2; pcf = pc; return; end
      for (int l = 0; l < NT; l++) begin
        int x = int'(mrd(l, s1)), y = int'(mrd(l, s2)), r;
        case (op)
          0: r = x + y;
          1: r = x - y;
          2: r = x * y;
          3: r = x & y;
          4: r = x | y;
          5: r = x ^ y;
          6: r = int'(mimem[pc][7:0]);
          default: r = -1;
        endcase
        if (op <= 6 && rd != 0 && rd != NR - 1) mregs[l][rd] = DW'(r % 65536);
      end
      if (pc == ID - 1) begin edges = 4 * ID; pcf = pc; return; end
      pc++;
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < NT; l++) for (int r = 0; r < NR; r++) mregs[l][r] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; start = 0; imem_we = 0; start8 = 0; we8 = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    clear_model();
  endtask

  task automatic load(input logic [31:0] prog[$]);
    foreach (prog[i]) begin
      @(negedge clk);
      imem_we = 1; imem_addr = 6'(i); imem_wdata = prog[i];
      mimem[i] = prog[i];
    end
    @(negedge clk);
    imem_we = 0;
  endtask

  task automatic peek(input int l, input int r, output logic [DW-1:0] v);
    dbg_thread = 2'(l); dbg_reg = 4'(r);
    #1 v = dbg_rdata;
  endtask

  task automatic launch(input bit disturb, output int got);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    got = -1;
    for (int e = 1; e <= 4 * ID + 8; e++) begin
      @(posedge clk);
      #1;
      if (disturb && e == 8) begin start = 1; imem_we = 1; imem_addr = '0; imem_wdata = 32'h7000; end
      if (disturb && e == 9) begin start = 0; imem_we = 0; end
      if (done) begin got = e; break; end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    do_reset();
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || pc_o !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_outputs busy=%b done=%b pc=%0d exp 0 0 0", busy, done, pc_o);
    end
    for (int l = 0; l < NT; l++) for (int r = 0; r < NR; r++) begin
      peek(l, r, v);
      vectors++;
      if (v !== mrd(l, r)) begin
        miscompares++;
        $display("FAIL reset_reg lane%0d R%0d got %h exp %h", l, r, v, mrd(l, r));
      end
    end
  endtask

  task automatic check_basic(input string tag, input bit disturb);
    int got, ed, pf;
    logic [DW-1:0] v;
    launch(disturb, got);
    model_run(ed, pf);
    vectors++;
    if (got !== 26) begin miscompares++; $display("FAIL %s_done_edge got %0d exp 26", tag, got); end
    for (int l = 0; l < NT; l++) begin
      peek(l, 3, v); vectors++;
      if (v !== 16'd15) begin miscompares++; $display("FAIL %s_r3 lane%0d got %0d exp 15", tag, l, v); end
      peek(l, 4, v); vectors++;
      if (v !== 16'd5) begin miscompares++; $display("FAIL %s_r4 lane%0d got %0d exp 5", tag, l, v); end
      peek(l, 5, v); vectors++;
      if (v !== 16'd100) begin miscompares++; $display("FAIL %s_r5 lane%0d got %0d exp 100", tag, l, v); end
      peek(l, 6, v); vectors++;
      if (v !== DW'(l + 5)) begin miscompares++; $display("FAIL %s_r6 lane%0d got %0d exp %0d", tag, l, v, l + 5); end
    end
  endtask

  task automatic test_basic();
    load('{32'h6105, 32'h620A, 32'h0312, 32'h1421, 32'h2522, 32'h06F1, 32'h7000});
    check_basic("basic", 0);
  endtask

  task automatic test_back_to_back();
    check_basic("b2b", 0);
  endtask

  task automatic test_wrap();
    int got, ed, pf;
    logic [DW-1:0] v;
    load('{32'h61FF, 32'h1301, 32'h2211, 32'h6410, 32'h2524, 32'h7000});
    launch(0, got);
    model_run(ed, pf);
    vectors++;
    if (got !== 22) begin miscompares++; $display("FAIL wrap_done_edge got %0d exp 22", got); end
    for (int l = 0; l < NT; l++) begin
      peek(l, 3, v); vectors++;
      if (v !== 16'hFF01) begin miscompares++; $display("FAIL wrap_r3 lane%0d got %h exp ff01", l, v); end
      peek(l, 2, v); vectors++;
      if (v !== 16'hFE01) begin miscompares++; $display("FAIL wrap_r2 lane%0d got %h exp fe01", l, v); end
      peek(l, 5, v); vectors++;
      if (v !== 16'hE010) begin miscompares++; $display("FAIL wrap_r5 lane%0d got %h exp e010", l, v); end
    end
  endtask

  task automatic test_protected();
    int got, ed, pf;
    logic [DW-1:0] v;
    load('{32'h6F07, 32'h6007, 32'h7000});
    launch(0, got);
    model_run(ed, pf);
    vectors++;
    if (got !== 10) begin miscompares++; $display("FAIL prot_done_edge got %0d exp 10", got); end
    for (int l = 0; l < NT; l++) begin
      peek(l, 15, v); vectors++;
      if (v !== DW'(l)) begin miscompares++; $display("FAIL prot_r15 lane%0d got %0d exp %0d", l, v, l); end
      peek(l, 0, v); vectors++;
      if (v !== '0) begin miscompares++; $display("FAIL prot_r0 lane%0d got %0d exp 0", l, v); end
    end
  endtask

  task automatic test_ignored_busy();
    load('{32'h6105, 32'h620A, 32'h0312, 32'h1421, 32'h2522, 32'h06F1, 32'h7000});
    check_basic("busy_ign", 1);
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] v;
    do_reset();
    load('{32'h6105, 32'h620A, 32'h0312, 32'h1421, 32'h2522, 32'h06F1, 32'h7000});
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state busy=%b done=%b exp 0 0", busy, done);
    end
    peek(1, 3, v);
    vectors++;
    if (v !== '0) begin miscompares++; $display("FAIL midreset_r3 got %0d exp 0", v); end
    @(negedge clk);
    reset = 1;
    clear_model();
    load('{32'h6105, 32'h620A, 32'h0312, 32'h1421, 32'h2522, 32'h06F1, 32'h7000});
    check_basic("midreset_rerun", 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [31:0] prog[$];
      int k = $urandom_range(0, 10), got, ed, pf;
      logic [DW-1:0] v;
      for (int i = 0; i < k; i++) begin
        logic [3:0] op = 4'($urandom_range(0, 14));
        if (op == 4'd7) op = 4'd15;
        prog.push_back({16'($urandom), op, 12'($urandom)});
      end
      prog.push_back({16'($urandom), 4'd7, 12'($urandom)});
      load(prog);
      launch(0, got);
      model_run(ed, pf);
      vectors++;
      if (got !== ed) begin miscompares++; $display("FAIL rand%0d_done_edge got %0d exp %0d", n, got, ed); end
      vectors++;
      if (int'(pc_o) !== pf) begin miscompares++; $display("FAIL rand%0d_pc got %0d exp %0d", n, pc_o, pf); end
      for (int l = 0; l < NT; l++) for (int r = 0; r < NR; r++) begin
        peek(l, r, v);
        vectors++;
        if (v !== mrd(l, r)) begin
          miscompares++;
          $display("FAIL rand%0d_reg lane%0d R%0d got %h exp %h", n, l, r, v, mrd(l, r));
        end
      end
    end
  endtask

  task automatic test_run_off_end();
    int got = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we8 = 1; addr8 = 3'(i); wdata8 = 32'h6100 | 32'(i + 1);
    end
    @(negedge clk);
    we8 = 0;
    start8 = 1;
    @(posedge clk);
    #1 start8 = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (done8) begin got = e; break; end
    end
    vectors++;
    if (got !== 32) begin miscompares++; $display("FAIL runoff_done_edge got %0d exp 32", got); end
    vectors++;
    if (pc8 !== 3'd7) begin miscompares++; $display("FAIL runoff_pc got %0d exp 7", pc8); end
    dbg_thread = 2'd2; dbg_reg = 4'd1;
    #1;
    vectors++;
    if (dbg_rdata8 !== 16'd8) begin miscompares++; $display("FAIL runoff_r1 got %0d exp 8", dbg_rdata8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_protected();
    test_ignored_busy();
    test_mid_reset();
    test_random();
    test_run_off_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/simt_core.md
# simt_core

Parametrised multi-cycle SIMT execution core, the successor to the single-cycle, single-thread GPU datapath. One shared instruction stream runs in lockstep across `NUM_THREADS` lanes. Each lane has its own register file and ALU, and a read-only lane-ID register. The core sits under `gpu_top`: the host loads instruction memory, pulses `start`, waits for `done`, then reads results over the debug port.

## Interface
- `NUM_THREADS`, default 4: number of lanes, 1–16.
- `DATA_WIDTH`, default 16: register and ALU width, 8–32.
- `NUM_REGS`, default 16: registers per lane, 4–16. Register fields use their low `$clog2(NUM_REGS)` bits.
- `IMEM_DEPTH`, default 64: instruction words, power of two.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: launch request, sampled in IDLE or DONE.
- `busy`, out, 1: high in FETCH, DECODE, EXECUTE, WRITEBACK.
- `done`, out, 1: high while in DONE.
- `imem_we`, in, 1: instruction-memory write enable.
- `imem_addr`, in, `$clog2(IMEM_DEPTH)`: write address.
- `imem_wdata`, in, 32: instruction word.
- `dbg_thread`, in, `$clog2(NUM_THREADS)`: lane select for debug read.
- `dbg_reg`, in, `$clog2(NUM_REGS)`: register select for debug read.
- `dbg_rdata`, out, `DATA_WIDTH`: combinational register read.
- `pc_o`, out, `$clog2(IMEM_DEPTH)`: current PC.

## Operation
- Instruction fields: op = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0], imm8 = [7:0]. Bits [31:16] are ignored.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR: rd ← rs1 op rs2.
  - 6 LDI: rd ← zero-extended imm8.
  - 7 HALT.
  - 8–15: NOP.
- All arithmetic is modulo 2^`DATA_WIDTH`. MUL keeps the low `DATA_WIDTH` bits. SUB wraps.
- Register rules:
  - R0 always reads 0, and writes to it are dropped. This makes 0x00000000 a NOP.
  - R(`NUM_REGS`-1) reads as the lane index, and writes to it are dropped.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, DONE.
  - IDLE/DONE → FETCH on `start`, with pc ← 0.
  - FETCH → DECODE: latch the instruction register.
  - DECODE → DONE if the instruction is HALT; otherwise DECODE → EXECUTE, reading rs1/rs2 in every lane.
  - EXECUTE → WRITEBACK: latch per-lane ALU results.
  - WRITEBACK: all lanes write rd in the same cycle. If pc == `IMEM_DEPTH`-1, go to DONE (no wrap). Otherwise pc ← pc+1 and go to FETCH.
- Instruction-memory writes are accepted only in IDLE or DONE; they are ignored while `busy`.
- `start` while `busy` is ignored.
- Reset values:
  - state = IDLE, pc = 0, `busy` = 0, `done` = 0.
  - All writable registers = 0.
  - Instruction memory is not cleared.
- Reset asserted mid-run aborts on the next edge. No further register writes occur after that edge.

## Timing
- All outputs except `dbg_rdata` are registered.
- Edge 0 is the edge where `start` is sampled high:
  - Each non-HALT instruction takes 4 cycles.
  - HALT takes 2 cycles (FETCH, DECODE).
  - With K instructions followed by HALT, `done` is high after edge 4K+2.
  - Without HALT, running to the end of memory, `done` is high after edge 4·`IMEM_DEPTH`.
- Register writes are visible on `dbg_rdata` in the cycle after WRITEBACK.
- A back-to-back `start` in DONE relaunches with no idle cycle.

## Structure
- Package `gpu_pkg` holds:
  - the `opcode_t` enum (ADD..HALT);
  - the `state_t` enum;
  - the field bit-position localparams.
- Sub-module `simt_lane`, instantiated `NUM_THREADS` times through a generate loop. Parameters: `DATA_WIDTH`, `NUM_REGS`, `LANE_ID`. Contents: register file, ALU, result latch, write port, debug read port.
- `simt_core` holds the FSM, PC, instruction memory, instruction register and debug mux.

## Test plan
- **Basic program.** Defaults. Program:
  1. 0x6105 (LDI R1,5)
  2. 0x620A (LDI R2,10)
  3. 0x0312 (ADD R3,R1,R2)
  4. 0x1421 (SUB R4,R2,R1)
  5. 0x2522 (MUL R5,R2,R2)
  6. 0x06F1 (ADD R6,R15,R1)
  7. 0x7000 (HALT)

  Required: `done` high after edge 26. Every lane has R3 = 15, R4 = 5, R5 = 100. R6 = lane + 5, so lane 3 gives 8.
- **Wrap and truncation.**
  1. LDI R1,0xFF
  2. SUB R3,R0,R1
  3. MUL R2,R1,R1
  4. LDI R4,0x10
  5. MUL R5,R2,R4

  Required: R3 = 0xFF01, R2 = 0xFE01, R5 = 0xE010 (low 16 bits).
- **Protected registers.** Run 0x6F07 (LDI R15,7) then 0x6007 (LDI R0,7). Required: every lane's R15 still reads its lane index, and R0 reads 0.
- **Run-off-end.** `IMEM_DEPTH` = 8, no HALT. Required: `done` high after edge 32, `pc_o` = 7.
- **Mid-run reset.** Drive `reset` low at edge 10 of the basic program. Required: the next cycle shows IDLE with `busy` = 0, `done` = 0 and R3 = 0. Reloading and starting again gives the full basic-program results.
- **Ignored inputs while busy.** Pulse `start` and `imem_we` during execution. Required: the result values and the edge-26 `done` timing are unchanged.
